// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the cotm32 memory stage: FSM encoding,
// exception causes, load/store funct3 encodings and the pipeline payload structs.
package cotm32_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        DRAIN    = 2'd3
    } mem_state_e;

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b10:   return offset != 2'b00;
            2'b01:   return offset[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

package cotm32_pipeline_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
    } exmem_data_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        exc_valid;
        logic [3:0]  exc_cause;
    } memwb_data_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the fabric.
interface dmem_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic        i_dmem_err;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_err, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_err, i_dmem_rdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load-lane extraction with sign/zero extension.
module load_align
    import cotm32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [15:0] half [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = lane[offset];
    assign half_sel = half[offset[1]];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-bus transaction per load/store, stalls the
// front of the pipeline until the response, and presents the MEM/WB payload.
module mem_stage
    import cotm32_pkg::*;
    import cotm32_pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  exmem_data_t  i_data,
    input  logic         i_valid,
    input  logic         i_kill,
    output memwb_data_t  o_data,
    output logic         o_valid,
    output logic         o_stall,
    dmem_if.master       dmem
);

    mem_state_e state_reg, state_next;
    logic       gnt_pending_reg, gnt_pending_next;

    logic [XLEN-1:0] addr_reg;
    logic [3:0]      be_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;

    logic            mem_op;
    logic            misaligned;
    logic            issue;
    logic [1:0]      off_in;
    logic [XLEN-1:0] addr_in;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in;
    logic [XLEN-1:0] load_data;

    assign off_in     = i_data.alu_result[1:0];
    assign addr_in    = {i_data.alu_result[XLEN-1:2], 2'b00};
    assign mem_op     = i_valid & (i_data.mem_read | i_data.mem_write) & ~i_kill;
    assign misaligned = is_misaligned(i_data.funct3, off_in);
    assign issue      = mem_op & ~misaligned;

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = '0;
        if (i_data.mem_write) begin
            case (i_data.funct3)
                F3_SB: begin
                    be_in    = 4'b0001 << off_in;
                    wdata_in = {4{i_data.rs2_data[7:0]}};
                end
                F3_SH: begin
                    be_in    = 4'b0011 << off_in;
                    wdata_in = {2{i_data.rs2_data[15:0]}};
                end
                default: begin
                    be_in    = 4'b1111;
                    wdata_in = i_data.rs2_data;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (dmem.i_dmem_rdata),
        .offset (off_reg),
        .funct3 (funct3_reg),
        .result (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            gnt_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            gnt_pending_reg <= gnt_pending_next;
        end
    end

    // Bus fields are captured at issue so they stay stable while waiting for grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_reg   <= '0;
            be_reg     <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            off_reg    <= '0;
        end else if (state_reg == IDLE && issue) begin
            addr_reg   <= addr_in;
            be_reg     <= be_in;
            wdata_reg  <= wdata_in;
            we_reg     <= i_data.mem_write;
            funct3_reg <= i_data.funct3;
            off_reg    <= off_in;
        end
    end

    always_comb begin
        state_next       = state_reg;
        gnt_pending_next = gnt_pending_reg;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    state_next = dmem.i_dmem_gnt ? WAIT_RSP : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (i_kill) begin
                    state_next       = DRAIN;
                    gnt_pending_next = ~dmem.i_dmem_gnt;
                end else if (dmem.i_dmem_gnt) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response coinciding with the kill closes the transaction outright
                if (dmem.i_dmem_rvalid) begin
                    state_next = IDLE;
                end else if (i_kill) begin
                    state_next       = DRAIN;
                    gnt_pending_next = 1'b0;
                end
            end
            DRAIN: begin
                if (gnt_pending_reg) begin
                    if (dmem.i_dmem_gnt) begin
                        gnt_pending_next = 1'b0;
                    end
                end else if (dmem.i_dmem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_data.inst       = i_data.inst;
        o_data.pc         = i_data.pc;
        o_data.alu_result = i_data.alu_result;
        o_data.rd         = i_data.rd;
        o_data.mem_rdata  = '0;
        o_data.reg_write  = i_data.reg_write;
        o_data.exc_valid  = 1'b0;
        o_data.exc_cause  = 4'd0;
        o_valid           = 1'b0;
        o_stall           = 1'b0;
        dmem.o_dmem_req   = 1'b0;
        dmem.o_dmem_addr  = addr_reg;
        dmem.o_dmem_be    = be_reg;
        dmem.o_dmem_wdata = wdata_reg;
        dmem.o_dmem_we    = we_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op && misaligned) begin
                    o_valid          = 1'b1;
                    o_data.exc_valid = 1'b1;
                    o_data.exc_cause = i_data.mem_write ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
                    o_data.reg_write = 1'b0;
                end else if (mem_op) begin
                    dmem.o_dmem_req   = 1'b1;
                    dmem.o_dmem_addr  = addr_in;
                    dmem.o_dmem_be    = be_in;
                    dmem.o_dmem_wdata = wdata_in;
                    dmem.o_dmem_we    = i_data.mem_write;
                    o_stall           = 1'b1;
                end else begin
                    o_valid = i_valid & ~i_kill;
                end
            end
            WAIT_GNT: begin
                dmem.o_dmem_req = 1'b1;
                o_stall         = 1'b1;
            end
            WAIT_RSP: begin
                if (dmem.i_dmem_rvalid && !i_kill) begin
                    o_valid          = 1'b1;
                    o_data.exc_valid = dmem.i_dmem_err;
                    o_data.reg_write = i_data.reg_write & ~we_reg & ~dmem.i_dmem_err;
                    o_data.mem_rdata = (we_reg || dmem.i_dmem_err) ? '0 : load_data;
                    if (dmem.i_dmem_err) begin
                        o_data.exc_cause = we_reg ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                    end
                end else begin
                    o_stall = 1'b1;
                end
            end
            DRAIN: begin
                dmem.o_dmem_req = gnt_pending_reg;
                if (mem_op) begin
                    o_stall = 1'b1;
                end else begin
                    o_valid = i_valid & ~i_kill;
                end
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
        // Handshake outputs drop the moment reset is asserted
        if (!i_rst_n) begin
            o_valid         = 1'b0;
            o_stall         = 1'b0;
            dmem.o_dmem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an arithmetic reference model.
module tb_mem_stage;
    import cotm32_pkg::*;
    import cotm32_pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    exmem_data_t in_d;
    logic        in_valid;
    logic        in_kill;
    memwb_data_t out_d;
    logic        out_valid;
    logic        out_stall;

    int compared = 0;
    int mismatched = 0;

    dmem_if bus ();

    mem_stage #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (in_d),
        .i_valid (in_valid),
        .i_kill  (in_kill),
        .o_data  (out_d),
        .o_valid (out_valid),
        .o_stall (out_stall),
        .dmem    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        int unsigned sh;
        sh = (a % 4) * 8;
        b  = (w >> sh) & 32'hFF;
        h  = (w >> sh) & 32'hFFFF;
        case (f3)
            3'd0:    return b - ((b & 32'h80) << 1);
            3'd4:    return b;
            3'd1:    return h - ((h & 32'h8000) << 1);
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
        case (f3)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return 4'(3 << (a % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [2:0] f3);
        case (f3)
            3'd0:    return (rs2 & 32'hFF) * 32'h01010101;
            3'd1:    return (rs2 & 32'hFFFF) * 32'h00010001;
            default: return rs2;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
        int unsigned size;
        size = 1 << (f3 % 4);
        return (a % size) != 0;
    endfunction

    task automatic set_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input bit rw);
        in_d.inst       = $urandom;
        in_d.pc         = $urandom;
        in_d.alu_result = addr;
        in_d.rs2_data   = rs2;
        in_d.mem_read   = rd_en;
        in_d.mem_write  = wr_en;
        in_d.funct3     = f3;
        in_d.rd         = 5'($urandom);
        in_d.reg_write  = rw;
    endtask

    task automatic bus_idle();
        bus.i_dmem_gnt    = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_err    = 1'b0;
        bus.i_dmem_rdata  = $urandom;
    endtask

    // Aligned load/store: grant g cycles after issue, response r cycles after grant.
    task automatic run_op(input string tag, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int g, input int r, input logic [31:0] rdata,
                          input bit err, input logic [31:0] exp_rdata);
        set_op(!st, st, f3, addr, rs2, 1'b1);
        in_valid = 1'b1;
        in_kill  = 1'b0;
        for (int c = 0; c <= g + r; c++) begin
            bus.i_dmem_gnt    = (c == g);
            bus.i_dmem_rvalid = (c == g + r);
            bus.i_dmem_err    = (c == g + r) && err;
            bus.i_dmem_rdata  = (c == g + r) ? rdata : $urandom;
            @(negedge clk);
            chk({tag, ".ctl"}, {bus.o_dmem_req, out_stall, out_valid},
                {29'd0, c <= g, c < g + r, c == g + r});
            if (c <= g) begin
                chk({tag, ".addr"}, bus.o_dmem_addr, addr & ~32'h3);
                chk({tag, ".we"}, bus.o_dmem_we, st);
                if (st) begin
                    chk({tag, ".be"}, bus.o_dmem_be, ref_be(addr, f3));
                    chk({tag, ".wdata"}, bus.o_dmem_wdata, ref_wdata(rs2, f3));
                end
            end
            if (c == g + r) begin
                chk({tag, ".reg_write"}, out_d.reg_write, !st && !err);
                chk({tag, ".exc_valid"}, out_d.exc_valid, err);
                chk({tag, ".rd"}, out_d.rd, in_d.rd);
                if (err) chk({tag, ".exc_cause"}, out_d.exc_cause, st ? 32'd7 : 32'd5);
                else if (st) chk({tag, ".mem_rdata"}, out_d.mem_rdata, 32'd0);
                else chk({tag, ".mem_rdata"}, out_d.mem_rdata, exp_rdata);
            end
            @(posedge clk);
            #1;
        end
        bus_idle();
        in_valid = 1'b0;
    endtask

    task automatic run_misaligned(input string tag, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] exp_cause);
        set_op(!st, st, f3, addr, $urandom, 1'b1);
        in_valid = 1'b1;
        in_kill  = 1'b0;
        bus_idle();
        @(negedge clk);
        chk({tag, ".ctl"}, {bus.o_dmem_req, out_stall, out_valid}, 32'b001);
        chk({tag, ".exc_valid"}, out_d.exc_valid, 32'd1);
        chk({tag, ".exc_cause"}, out_d.exc_cause, exp_cause);
        chk({tag, ".reg_write"}, out_d.reg_write, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_alu(input string tag);
        bit rw;
        rw = 1'($urandom);
        set_op(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, rw);
        in_valid = 1'b1;
        in_kill  = 1'b0;
        bus_idle();
        @(negedge clk);
        chk({tag, ".ctl"}, {bus.o_dmem_req, out_stall, out_valid}, 32'b001);
        chk({tag, ".alu_result"}, out_d.alu_result, in_d.alu_result);
        chk({tag, ".reg_write"}, out_d.reg_write, rw);
        chk({tag, ".exc_valid"}, out_d.exc_valid, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] load_f3 [5];
        logic [2:0] store_f3 [3];
        load_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        store_f3 = '{3'd0, 3'd1, 3'd2};

        in_d     = '0;
        in_valid = 1'b0;
        in_kill  = 1'b0;
        bus_idle();

        // Reset holds handshake outputs low even with a memory op presented
        set_op(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 1'b1);
        in_valid = 1'b1;
        #12;
        chk("reset.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b000);
        @(posedge clk);
        #1;

        run_op("sw_basic", 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 1, $urandom, 1'b0, 32'h0);
        run_op("lb_203",  1'b0, F3_LB,  32'h203, 32'h0, 0, 1, 32'h80FF7F01, 1'b0, 32'hFFFFFF80);
        run_op("lbu_203", 1'b0, F3_LBU, 32'h203, 32'h0, 0, 1, 32'h80FF7F01, 1'b0, 32'h00000080);
        run_op("lh_202",  1'b0, F3_LH,  32'h202, 32'h0, 0, 1, 32'h80FF7F01, 1'b0, 32'hFFFF80FF);
        run_op("lhu_200", 1'b0, F3_LHU, 32'h200, 32'h0, 0, 1, 32'h80FF7F01, 1'b0, 32'h00007F01);
        run_misaligned("lw_102", 1'b0, F3_LW, 32'h102, 32'd4);
        run_misaligned("sh_101", 1'b1, F3_SH, 32'h101, 32'd6);
        run_op("sb_slow", 1'b1, F3_SB, 32'h3C1, 32'h000000A5, 3, 2, $urandom, 1'b0, 32'h0);
        run_op("lw_err",  1'b0, F3_LW, 32'h240, 32'h0, 1, 1, $urandom, 1'b1, 32'h0);
        run_op("sw_err",  1'b1, F3_SW, 32'h244, 32'h12345678, 0, 2, $urandom, 1'b1, 32'h0);

        // Kill while waiting for grant, then a load presented during the drain
        set_op(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 1'b1);
        in_valid = 1'b1;
        bus_idle();
        @(negedge clk);
        chk("kill.issue.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b110);
        @(posedge clk);
        #1;
        in_kill = 1'b1;
        @(negedge clk);
        chk("kill.cycle.req_valid", {bus.o_dmem_req, out_valid}, 32'b10);
        chk("kill.cycle.addr", bus.o_dmem_addr, 32'h300);
        @(posedge clk);
        #1;
        in_kill = 1'b0;
        set_op(1'b1, 1'b0, F3_LW, 32'h404, 32'h0, 1'b1);
        @(negedge clk);
        chk("drain.pending.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b110);
        chk("drain.pending.addr", bus.o_dmem_addr, 32'h300);
        @(posedge clk);
        #1;
        bus.i_dmem_gnt = 1'b1;
        @(negedge clk);
        chk("drain.gnt.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b110);
        @(posedge clk);
        #1;
        bus.i_dmem_gnt = 1'b0;
        @(negedge clk);
        chk("drain.wait.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b010);
        @(posedge clk);
        #1;
        bus.i_dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("drain.rsp.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b010);
        @(posedge clk);
        #1;
        bus_idle();
        run_op("lw_after_drain", 1'b0, F3_LW, 32'h404, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);

        // Randomized mix of ALU, aligned and misaligned memory ops
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            bit          st;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [31:0] rdata;
            bit          err;
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                run_alu($sformatf("rnd%0d.alu", n));
            end else begin
                st    = 1'($urandom);
                f3    = st ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
                addr  = $urandom;
                if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << (f3 % 4)) - 1);
                rdata = $urandom;
                err   = ($urandom_range(0, 7) == 0);
                if (ref_misaligned(addr, f3))
                    run_misaligned($sformatf("rnd%0d.mis", n), st, f3, addr, st ? 32'd6 : 32'd4);
                else
                    run_op($sformatf("rnd%0d.mem", n), st, f3, addr, $urandom,
                           $urandom_range(0, 3), $urandom_range(1, 3), rdata, err,
                           ref_load(rdata, addr, f3));
            end
        end

        // Asynchronous reset while waiting for a response
        set_op(1'b1, 1'b0, F3_LW, 32'h500, 32'h0, 1'b1);
        in_valid = 1'b1;
        bus.i_dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_mid.issue.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b110);
        @(posedge clk);
        #1;
        bus_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.async.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b000);
        @(negedge clk);
        chk("rst_mid.held.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.release.ctl", {bus.o_dmem_req, out_stall, out_valid}, 32'b000);
        @(posedge clk);
        #1;
        run_op("lw_after_reset", 1'b0, F3_LW, 32'h504, 32'h0, 1, 1, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
